bm_log_range_reduce: RTL and testbench

Pipelined range-reduction front end for the Box-Muller -2·ln(u0) path. Accepts a 32-bit uniform sample u0 and counts its leading zeros with the design's 32-bit leading-zero detector. Outputs exponent e = lz+1 and normalised mantissa x_e = u0 << e, hidden leading one dropped. Sits between the uniform generator (URNG) and the ln polynomial evaluator, with valid/ready handshake on both sides.

---
 rtl/bm_pkg.sv | 32 +++
 rtl/lzd32.sv | 22 ++
 rtl/bm_log_range_reduce.sv | 86 ++++++++
 tb/tb_bm_log_range_reduce.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/bm_pkg.sv
// Shared types and constants for the Box-Muller log path: stage payload and
// the exponent/mantissa bundle consumed by the ln polynomial evaluator.
package bm_pkg;

    localparam int U0_W  = 32;
    localparam int EXP_W = 6;
    localparam int LZ_W  = 5;

    typedef struct packed {
        logic [U0_W-1:0] data;
        logic [LZ_W-1:0] lz;
        logic            nz;
    } stage_t;

    typedef struct packed {
        logic [EXP_W-1:0] exponent;
        logic [U0_W-1:0]  mantissa;
        logic             zero;
    } exp_mant_t;

    // A zero sample saturates to e=32 with an empty mantissa.
    function automatic exp_mant_t pack_result(input logic [U0_W-1:0] sh,
                                              input logic [LZ_W-1:0] lz,
                                              input logic            nz);
        exp_mant_t r;
        r.zero     = ~nz;
        r.exponent = nz ? ({1'b0, lz} + 6'd1) : 6'd32;
        r.mantissa = nz ? {sh[U0_W-2:0], 1'b0} : {U0_W{1'b0}};
        return r;
    endfunction

endpackage

// File: rtl/lzd32.sv
// Combinational 32-bit leading-zero detector: p = count of leading zeros,
// v = input is nonzero (p is 0 when v is 0).
module lzd32 (
    input  logic [31:0] d,
    output logic [4:0]  p,
    output logic        v
);

    logic found_s;

    // Scan from the MSB; the first set bit fixes the count.
    always_comb begin
        p       = 5'd0;
        found_s = 1'b0;
        for (int i = 31; i >= 0; i--) begin
            p       = (~found_s & d[i]) ? 5'(31 - i) : p;
            found_s = found_s | d[i];
        end
        v = found_s;
    end

endmodule

// File: rtl/bm_log_range_reduce.sv
// Three-stage range reduction for -2*ln(u0): u0 -> (e = lz+1, x_e = u0 << e)
// with valid/ready on both sides and collapsing bubbles.
module bm_log_range_reduce #(
    parameter int DATA_W = 32,
    parameter int EXP_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [EXP_W-1:0]  out_exp,
    output logic [DATA_W-1:0] out_mant,
    output logic              out_zero
);
    import bm_pkg::*;

    if (DATA_W != 32) begin : g_bad_width
        $error("bm_log_range_reduce supports DATA_W = 32 only");
    end

    logic        v1_r;
    logic [31:0] d1_r;
    logic        v2_r;
    stage_t      s2_r;

    logic [4:0]  lz_s;
    logic        nz_s;
    logic        mv1_s;
    logic        mv2_s;
    logic        mv3_s;
    exp_mant_t   res_s;

    lzd32 u_lzd (
        .d (d1_r),
        .p (lz_s),
        .v (nz_s)
    );

    // Each stage may load when it is empty or its content moves on this edge.
    always_comb begin
        mv3_s    = ~out_valid | out_ready;
        mv2_s    = ~v2_r | mv3_s;
        mv1_s    = ~v1_r | mv2_s;
        in_ready = ~rst & mv1_s;
        res_s    = pack_result(s2_r.data, s2_r.lz, s2_r.nz);
    end

    // Pipeline registers; payloads only load alongside a valid token.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_r      <= 1'b0;
            d1_r      <= 32'd0;
            v2_r      <= 1'b0;
            s2_r      <= '{data: 32'd0, lz: 5'd0, nz: 1'b0};
            out_valid <= 1'b0;
            out_exp   <= 6'd0;
            out_mant  <= 32'd0;
            out_zero  <= 1'b0;
        end else begin
            if (mv1_s) begin
                v1_r <= in_valid;
                if (in_valid) begin
                    d1_r <= in_data;
                end
            end
            if (mv2_s) begin
                v2_r <= v1_r;
                if (v1_r) begin
                    s2_r <= '{data: d1_r << lz_s, lz: lz_s, nz: nz_s};
                end
            end
            if (mv3_s) begin
                out_valid <= v2_r;
                if (v2_r) begin
                    out_exp  <= res_s.exponent;
                    out_mant <= res_s.mantissa;
                    out_zero <= res_s.zero;
                end
            end
        end
    end

endmodule

// File: tb/tb_bm_log_range_reduce.sv
// Directed bench for bm_log_range_reduce: vector table, streaming,
// backpressure and mid-flight reset, with a queue scoreboard on the output.
module tb_bm_log_range_reduce;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  out_exp;
    logic [31:0] out_mant;
    logic        out_zero;

    int checks = 0;
    int errors = 0;
    int pops   = 0;
    logic [38:0] sb_q[$];

    typedef struct {
        logic [31:0] u;
        logic [5:0]  e;
        logic [31:0] m;
        logic        z;
    } vec_t;
    vec_t vecs[7];

    always #5 clk = ~clk;

    bm_log_range_reduce dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_exp   (out_exp),
        .out_mant  (out_mant),
        .out_zero  (out_zero)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Reference: normalise by shifting until the MSB is set.
    function automatic logic [38:0] model(input logic [31:0] u);
        logic [31:0] x;
        logic [31:0] m;
        logic [5:0]  e;
        if (u == 32'd0) return {6'd32, 32'd0, 1'b1};
        x = u;
        e = 6'd1;
        while (!x[31]) begin
            x = x << 1;
            e = e + 6'd1;
        end
        m = x << 1;
        return {e, m, 1'b0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: push accepted inputs, compare every delivered output.
    always @(negedge clk) begin
        if (rst) begin
            sb_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_output", 64'd1, 64'd0);
                end else begin
                    check("sb_result", {out_exp, out_mant, out_zero}, sb_q.pop_front());
                    pops++;
                end
            end
            if (in_valid && in_ready) sb_q.push_back(model(in_data));
        end
    end

    task automatic send_one(input vec_t v, input string tag);
        int lat;
        lat      = 0;
        in_valid = 1'b1;
        in_data  = v.u;
        tick();
        in_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (out_valid) begin
                lat = k;
                break;
            end
            tick();
        end
        check({tag, "_latency"}, lat, 3);
        check({tag, "_result"}, {out_exp, out_mant, out_zero}, {v.e, v.m, v.z});
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] ov;
        logic [38:0] held;
        logic [31:0] bp_data[8];
        int acc;
        int seen;
        int p0;

        vecs[0] = '{32'h8000_0000, 6'd1,  32'h0000_0000, 1'b0};
        vecs[1] = '{32'h00F0_0000, 6'd9,  32'hE000_0000, 1'b0};
        vecs[2] = '{32'h0000_0001, 6'd32, 32'h0000_0000, 1'b0};
        vecs[3] = '{32'h0000_0000, 6'd32, 32'h0000_0000, 1'b1};
        vecs[4] = '{32'hFFFF_FFFF, 6'd1,  32'hFFFF_FFFE, 1'b0};
        vecs[5] = '{32'h4000_0001, 6'd2,  32'h0000_0004, 1'b0};
        vecs[6] = '{32'h0001_2345, 6'd16, 32'h2345_0000, 1'b0};
        for (int i = 0; i < 8; i++) bp_data[i] = 32'h0000_1000 << i;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 32'd0;
        out_ready = 1'b1;
        tick();
        check("reset_in_ready", in_ready, 0);
        tick();
        check("reset_outputs", {out_valid, out_exp, out_mant, out_zero}, 0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) send_one(vecs[i], $sformatf("vec%0d", i));

        // Back-to-back stream of 8 random samples.
        p0 = pops;
        ov = 16'd0;
        for (int k = 0; k < 16; k++) begin
            in_valid = (k < 8);
            in_data  = $urandom;
            #1;
            if (k < 8) check("stream_in_ready", in_ready, 1);
            tick();
            ov[k] = out_valid;
        end
        in_valid = 1'b0;
        check("stream_valid_pattern", ov, 16'h03FC);
        check("stream_count", pops - p0, 8);

        // Backpressure: pipeline fills with three samples, then stalls.
        p0        = pops;
        acc       = 0;
        seen      = 0;
        held      = 39'd0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = bp_data[0];
        for (int c = 0; c < 6; c++) begin
            #1;
            if (in_ready) acc++;
            tick();
            in_data = bp_data[acc];
            if (out_valid) begin
                if (seen == 0) begin
                    held = {out_exp, out_mant, out_zero};
                    seen = 1;
                end else begin
                    check("stall_hold_stable", {out_exp, out_mant, out_zero}, held);
                end
            end
        end
        check("stall_accepted", acc, 3);
        check("stall_first_out", held, model(bp_data[0]));
        #1;
        check("stall_in_ready_low", in_ready, 0);
        out_ready = 1'b1;
        #1;
        check("pass_through_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 6; k++) tick();
        check("stall_drain_count", pops - p0, 4);

        // Reset with three samples in flight.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_data = 32'hA5A5_0000 + 32'(k);
            tick();
        end
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        check("midreset_in_ready", in_ready, 0);
        tick();
        check("midreset_outputs", {out_valid, out_exp, out_mant, out_zero}, 0);
        rst       = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("midreset_no_ghost", out_valid, 0);
        end
        send_one(vecs[1], "post_reset");

        check("sb_empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
